framebuffer_rect_fill: RTL and testbench

- Write-only pixel source that fills an axis-aligned rectangle of the framebuffer with one colour, one pixel per clock.
- Drives one channel input (chN_fbuf_*) of the framebuffer channel mux, directly upstream of it.
- Typical jobs are screen clears, background panels and UI boxes.
- Clips the rectangle to the screen and stalls on a grant signal that tracks the mux select.

---
 rtl/fbuf_pkg.sv | 21 ++
 rtl/framebuffer_rect_fill.sv | 189 ++++++++++++++++++
 tb/tb_framebuffer_rect_fill.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fbuf_pkg.sv
// fbuf_pkg: constants shared by the framebuffer clients (rectangle fill,
// channel mux, display scan-out) plus the rectangle-fill state encoding.
//   FBUF_ADDR_WIDTH / FBUF_DATA_WIDTH : BRAM address / pixel width
//   H_RES / V_RES                     : screen size, H_RES is also the row pitch
//   COORD_WIDTH                       : width of the x/y/w/h job coordinates
package fbuf_pkg;

  localparam int FBUF_ADDR_WIDTH = 19;
  localparam int FBUF_DATA_WIDTH = 8;
  localparam int H_RES           = 640;
  localparam int V_RES           = 480;
  localparam int COORD_WIDTH     = 10;

  typedef enum logic [1:0] {
    FILL_IDLE  = 2'd0,
    FILL_SETUP = 2'd1,
    FILL_WRITE = 2'd2,
    FILL_DONE  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/framebuffer_rect_fill.sv
// framebuffer_rect_fill: fills a screen-clipped axis-aligned rectangle with a
// single colour, one pixel per granted clock, into one framebuffer mux channel.
//
// state | meaning
// IDLE  | waiting for start, job parameters latched on acceptance
// SETUP | clip limits and first row base computed, empty jobs skip to DONE
// WRITE | one pixel per cycle while grant=1, position held while grant=0
// DONE  | single cycle that produces the done pulse and drops busy
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, x0, y0, w, h   job request and rectangle (left, top, width, height)
//   colour                fill value
//   grant                 1 = this channel owns the framebuffer this cycle
//   busy, done            job in progress, one-cycle completion pulse
//   fbuf_en_wr, fbuf_wrea BRAM enable / write enable
//   fbuf_addr, fbuf_data  write address (y*H_RES + x) and data
//   fbuf_rst_req_n        constant 1, this client never resets the framebuffer
module framebuffer_rect_fill #(
  parameter int FBUF_ADDR_WIDTH = fbuf_pkg::FBUF_ADDR_WIDTH,
  parameter int FBUF_DATA_WIDTH = fbuf_pkg::FBUF_DATA_WIDTH,
  parameter int H_RES           = fbuf_pkg::H_RES,
  parameter int V_RES           = fbuf_pkg::V_RES,
  parameter int COORD_WIDTH     = fbuf_pkg::COORD_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [COORD_WIDTH-1:0]     x0,
  input  logic [COORD_WIDTH-1:0]     y0,
  input  logic [COORD_WIDTH-1:0]     w,
  input  logic [COORD_WIDTH-1:0]     h,
  input  logic [FBUF_DATA_WIDTH-1:0] colour,
  input  logic                       grant,
  output logic                       busy,
  output logic                       done,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  output logic                       fbuf_rst_req_n
);
  import fbuf_pkg::*;

  if (longint'(H_RES) * longint'(V_RES) > (longint'(1) << FBUF_ADDR_WIDTH)) begin : g_addr_width_check
    $error("framebuffer_rect_fill: H_RES*V_RES does not fit in FBUF_ADDR_WIDTH bits");
  end

  // One extra bit so x0+w / y0+h never wrap before clipping.
  localparam int CW1 = COORD_WIDTH + 1;
  localparam int AW  = FBUF_ADDR_WIDTH;
  localparam int DW  = FBUF_DATA_WIDTH;

  localparam logic [CW1-1:0] H_RES_C = CW1'(H_RES);
  localparam logic [CW1-1:0] V_RES_C = CW1'(V_RES);
  localparam logic [AW-1:0]  PITCH_A = AW'(H_RES);

  fill_state_e state_q, state_d;

  logic [COORD_WIDTH-1:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [DW-1:0]          colour_q, colour_d;
  logic [CW1-1:0]         x_q, x_d, y_q, y_d, x_end_q, x_end_d, y_end_q, y_end_d;
  logic [AW-1:0]          row_base_q, row_base_d;

  logic          busy_q, busy_d, done_q, done_d, en_q, en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [CW1-1:0] x_sum, y_sum, x_nxt, y_nxt;
  logic           job_empty;

  always_comb begin
    x_sum     = CW1'(x0_q) + CW1'(w_q);
    y_sum     = CW1'(y0_q) + CW1'(h_q);
    x_nxt     = x_q + CW1'(1);
    y_nxt     = y_q + CW1'(1);
    job_empty = (w_q == '0) || (h_q == '0) ||
                (CW1'(x0_q) >= H_RES_C) || (CW1'(y0_q) >= V_RES_C);

    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    colour_d   = colour_q;
    x_d        = x_q;
    y_d        = y_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    en_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    unique case (state_q)
      FILL_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          x0_d     = x0;
          y0_d     = y0;
          w_d      = w;
          h_d      = h;
          colour_d = colour;
          busy_d   = 1'b1;
          state_d  = FILL_SETUP;
        end
      end
      FILL_SETUP: begin
        x_end_d    = (x_sum > H_RES_C) ? H_RES_C : x_sum;
        y_end_d    = (y_sum > V_RES_C) ? V_RES_C : y_sum;
        // Truncation only matters for y0 >= V_RES, which is an empty job.
        row_base_d = AW'(y0_q) * PITCH_A;
        x_d        = CW1'(x0_q);
        y_d        = CW1'(y0_q);
        state_d    = job_empty ? FILL_DONE : FILL_WRITE;
      end
      FILL_WRITE: begin
        if (grant) begin
          en_d   = 1'b1;
          addr_d = row_base_q + AW'(x_q);
          data_d = colour_q;
          if (x_nxt == x_end_q) begin
            x_d        = CW1'(x0_q);
            y_d        = y_nxt;
            row_base_d = row_base_q + PITCH_A;
            if (y_nxt == y_end_q) state_d = FILL_DONE;
          end else begin
            x_d = x_nxt;
          end
        end
      end
      FILL_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      colour_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      colour_q   <= colour_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign fbuf_en_wr     = en_q;
  assign fbuf_wrea      = en_q;
  assign fbuf_addr      = addr_q;
  assign fbuf_data      = data_q;
  assign fbuf_rst_req_n = 1'b1;

endmodule

// File: tb/tb_framebuffer_rect_fill.sv
module tb_framebuffer_rect_fill;
  import fbuf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, grant;
  logic [9:0]  x0, y0, w, h;
  logic [7:0]  colour;
  logic        busy, done, fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  framebuffer_rect_fill dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .colour(colour), .grant(grant),
    .busy(busy), .done(done), .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea),
    .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data), .fbuf_rst_req_n(fbuf_rst_req_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [18:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [18:0] exp_q[$];
  int          wrea_bad = 0;
  bit          rand_grant = 1'b0;

  // Write capture, sampled on the falling edge.
  always @(negedge clk) begin
    if (fbuf_en_wr === 1'b1) begin
      wr_addr.push_back(fbuf_addr);
      wr_data.push_back(fbuf_data);
    end
    if (fbuf_en_wr !== fbuf_wrea) wrea_bad++;
  end

  initial forever begin
    @(negedge clk);
    if (rand_grant) grant = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: every on-screen pixel of the rectangle, row-major.
  task automatic model(input int mx0, input int my0, input int mw, input int mh);
    exp_q.delete();
    for (int yy = my0; yy < my0 + mh && yy < V_RES; yy++)
      for (int xx = mx0; xx < mx0 + mw && xx < H_RES; xx++)
        exp_q.push_back(19'(yy * H_RES + xx));
  endtask

  task automatic check_list(input string name, input logic [7:0] col);
    int bad_idx;
    bad_idx = -1;
    tests++;
    if (wr_addr.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (bad_idx < 0 && (wr_addr[i] !== exp_q[i] || wr_data[i] !== col)) bad_idx = i;
    end
    if (wr_addr.size() != exp_q.size() || bad_idx >= 0) begin
      fails++;
      if (bad_idx >= 0)
        $display("FAIL %s: write %0d got addr %0d data %0h, expected addr %0d data %0h",
                 name, bad_idx, wr_addr[bad_idx], wr_data[bad_idx], exp_q[bad_idx], col);
      else
        $display("FAIL %s: got %0d writes, expected %0d", name, wr_addr.size(), exp_q.size());
    end
  endtask

  task automatic launch(input int jx0, input int jy0, input int jw, input int jh, input int col);
    wr_addr.delete();
    wr_data.delete();
    x0 = 10'(jx0); y0 = 10'(jy0); w = 10'(jw); h = 10'(jh); colour = 8'(col);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns the cycle index (edges after acceptance) of the first write and
  // of the done pulse; -1 if not seen within the budget.
  task automatic run_job(input int jx0, input int jy0, input int jw, input int jh, input int col,
                         output int first_n, output int done_n);
    int n;
    launch(jx0, jy0, jw, jh, col);
    first_n = -1;
    done_n  = -1;
    n = 0;
    while (n < 20000) begin
      if (first_n < 0 && wr_addr.size() > 0) first_n = n;
      if (done === 1'b1) begin
        done_n = n;
        break;
      end
      step();
      n++;
    end
  endtask

  typedef struct {
    int x0, y0, w, h, col;
    int exp_n, exp_first, exp_last;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int first_n, done_n, n, sz;
    int en_mask, busy_after, stall_en, extra_writes;

    vecs[0] = '{1, 1, 2, 2, 'hAB, 4, 641, 1282};
    vecs[1] = '{638, 478, 5, 5, 'h5A, 4, 306558, 307199};
    vecs[2] = '{10, 10, 0, 5, 'h11, 0, 0, 0};
    vecs[3] = '{640, 0, 5, 5, 'h22, 0, 0, 0};
    vecs[4] = '{0, 480, 3, 3, 'h33, 0, 0, 0};
    vecs[5] = '{5, 5, 5, 0, 'h44, 0, 0, 0};
    vecs[6] = '{0, 470, 640, 480, 'hFF, 6400, 300800, 307199};
    vecs[7] = '{639, 0, 1, 1, 'hC3, 1, 639, 639};
    vecs[8] = '{1023, 1023, 1023, 1023, 'h99, 0, 0, 0};
    vecs[9] = '{600, 10, 1023, 2, 'h77, 80, 7000, 7679};

    rst_n = 1'b0; start = 1'b0; grant = 1'b1;
    x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
    repeat (3) step();
    check("reset en_wr", fbuf_en_wr, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rst_req_n", fbuf_rst_req_n, 1);
    check("reset addr", fbuf_addr, 0);
    rst_n = 1'b1;
    step();

    // Table of jobs with grant held high.
    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].col, first_n, done_n);
      check($sformatf("vec%0d write count", i), wr_addr.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0 && wr_addr.size() > 0) begin
        check($sformatf("vec%0d first addr", i), wr_addr[0], vecs[i].exp_first);
        check($sformatf("vec%0d last addr", i), wr_addr[wr_addr.size()-1], vecs[i].exp_last);
        check($sformatf("vec%0d first write cycle", i), first_n, 2);
      end
      check($sformatf("vec%0d done cycle", i), done_n,
            (vecs[i].exp_n == 0) ? 2 : vecs[i].exp_n + 2);
      check($sformatf("vec%0d busy at done", i), busy, 0);
      model(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h);
      check_list($sformatf("vec%0d write list", i), 8'(vecs[i].col));
      step();
      check($sformatf("vec%0d single done pulse", i), done, 0);
    end

    // Basic fill timing, start while busy (mid-job and in the DONE cycle).
    launch(1, 1, 2, 2, 'hAB);
    en_mask = 0; busy_after = 0; extra_writes = 0; done_n = -1;
    for (n = 0; n < 12; n++) begin
      if (fbuf_en_wr === 1'b1) en_mask |= (1 << n);
      if (done === 1'b1 && done_n < 0) done_n = n;
      if (n >= 7 && busy !== 1'b0) busy_after++;
      start = (n == 3 || n == 5);
      if (n == 3) begin x0 = 10'd200; y0 = 10'd200; w = 10'd9; h = 10'd9; end
      if (n == 5) begin x0 = 10'd0; y0 = 10'd0; w = 10'd1; h = 10'd1; end
      if (n == 6) sz = wr_addr.size();
      step();
    end
    start = 1'b0;
    extra_writes = wr_addr.size() - sz;
    check("basic write cycles mask", en_mask, 'b111100);
    check("basic done cycle", done_n, 6);
    check("start in DONE ignored (busy)", busy_after, 0);
    check("start in DONE ignored (writes)", extra_writes, 0);
    model(1, 1, 2, 2);
    check_list("basic with start while busy", 8'hAB);

    // Grant stall of 4 cycles after the first write.
    launch(0, 0, 3, 1, 'h3C);
    n = 0;
    while (wr_addr.size() == 0 && n < 10) begin step(); n++; end
    check("stall first write seen", wr_addr.size(), 1);
    grant = 1'b0;
    stall_en = 0;
    repeat (4) begin
      step();
      if (fbuf_en_wr !== 1'b0) stall_en++;
    end
    grant = 1'b1;
    check("stall en_wr low", stall_en, 0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin step(); n++; end
    check("stall done seen", done, 1);
    model(0, 0, 3, 1);
    check_list("stall write list", 8'h3C);
    step();

    // Reset in the middle of a full-screen fill.
    launch(0, 0, 640, 480, 'h5F);
    n = 0;
    while (wr_addr.size() < 100 && n < 200) begin step(); n++; end
    check("reset-job reached 100 writes", wr_addr.size(), 100);
    rst_n = 1'b0;
    step();
    check("midreset en_wr", fbuf_en_wr, 0);
    check("midreset wrea", fbuf_wrea, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset rst_req_n", fbuf_rst_req_n, 1);
    rst_n = 1'b1;
    sz = wr_addr.size();
    repeat (20) step();
    check("no writes after reset", wr_addr.size() - sz, 0);
    check("writes before reset", sz, 100);

    // Randomized jobs with random grant.
    rand_grant = 1'b1;
    for (int j = 0; j < 40; j++) begin
      int rx0, ry0, rw, rh, rc;
      rx0 = $urandom_range(0, 660); ry0 = $urandom_range(0, 500);
      rw  = $urandom_range(0, 9);   rh  = $urandom_range(0, 9);
      rc  = $urandom_range(0, 255);
      if (j % 4 == 0) begin rx0 = $urandom_range(630, 639); ry0 = $urandom_range(470, 479); end
      run_job(rx0, ry0, rw, rh, rc, first_n, done_n);
      check($sformatf("rand%0d done seen", j), (done_n >= 0), 1);
      model(rx0, ry0, rw, rh);
      check_list($sformatf("rand%0d (%0d,%0d %0dx%0d)", j, rx0, ry0, rw, rh), 8'(rc));
      step();
    end
    rand_grant = 1'b0;
    grant = 1'b1;
    step();

    check("wrea tracks en_wr", wrea_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
